regfile_check_sequencer: RTL and testbench

Synthesizable, parametrised successor to the processor auto-checker. It waits a programmable number of cycles after start, then walks a programmable table of (register, expected value) pairs through a spare register-file read port. It counts mismatches and captures the first failure, so on-board self-test needs no simulator. It sits beside the skeleton's register file and is driven by a debug/test controller.

---
 rtl/rf_check_pkg.sv | 26 ++
 rtl/rf_check_table.sv | 40 ++++
 rtl/regfile_check_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_regfile_check_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_check_pkg.sv
// Shared definitions for the register-file check sequencer: default widths,
// FSM state encoding and the layout of one check-table entry.
package rf_check_pkg;

   localparam int DEF_DATA_WIDTH     = 32;
   localparam int DEF_REG_ADDR_WIDTH = 5;
   localparam int DEF_NUM_CHECKS     = 8;
   localparam int DEF_IDX_WIDTH      = 3;
   localparam int DEF_LIMIT_WIDTH    = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_COLLECT = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   // One check: which register to read and the value it must hold. The table
   // module keeps the same {reg, value} pairing at the parametrised widths.
   typedef struct packed {
      logic [DEF_REG_ADDR_WIDTH-1:0] reg_addr;
      logic [DEF_DATA_WIDTH-1:0]     value;
   } entry_t;

endpackage

// File: rtl/rf_check_table.sv
// Check table: NUM_CHECKS entries of {register index, expected value} with one
// synchronous write port and one combinational read port. Not reset; entries
// are undefined until written.
module rf_check_table
   import rf_check_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
   parameter int NUM_CHECKS     = DEF_NUM_CHECKS,
   parameter int IDX_WIDTH      = DEF_IDX_WIDTH
) (
   input  logic                      clock,
   input  logic                      we,
   input  logic [IDX_WIDTH-1:0]      wr_idx,
   input  logic [REG_ADDR_WIDTH-1:0] wr_reg,
   input  logic [DATA_WIDTH-1:0]     wr_value,
   input  logic [IDX_WIDTH-1:0]      rd_idx,
   output logic [REG_ADDR_WIDTH-1:0] rd_reg,
   output logic [DATA_WIDTH-1:0]     rd_value
);

   logic [REG_ADDR_WIDTH-1:0] reg_mem_q [NUM_CHECKS];
   logic [DATA_WIDTH-1:0]     val_mem_q [NUM_CHECKS];

   // Write one entry on the strobe; gating against a running check is done
   // by the caller.
   always_ff @(posedge clock) begin
      if (we) begin
         reg_mem_q[wr_idx] <= wr_reg;
         val_mem_q[wr_idx] <= wr_value;
      end
   end

   // Combinational read of the entry the sequencer is currently working on.
   always_comb begin
      rd_reg   = reg_mem_q[rd_idx];
      rd_value = val_mem_q[rd_idx];
   end

endmodule

// File: rtl/regfile_check_sequencer.sv
// Register-file check sequencer: after a programmable delay it walks the check
// table through a spare register-file read port, counts mismatches and keeps
// the first failing entry for on-board self-test.
module regfile_check_sequencer
   import rf_check_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
   parameter int NUM_CHECKS     = DEF_NUM_CHECKS,
   parameter int IDX_WIDTH      = DEF_IDX_WIDTH,
   parameter int LIMIT_WIDTH    = DEF_LIMIT_WIDTH,
   parameter int READ_LATENCY   = 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic [LIMIT_WIDTH-1:0]    cycle_limit,
   input  logic [IDX_WIDTH:0]        num_checks,
   input  logic                      cfg_we,
   input  logic [IDX_WIDTH-1:0]      cfg_idx,
   input  logic [REG_ADDR_WIDTH-1:0] cfg_reg,
   input  logic [DATA_WIDTH-1:0]     cfg_value,
   output logic [REG_ADDR_WIDTH-1:0] rf_rd_addr,
   output logic                      rf_rd_en,
   input  logic [DATA_WIDTH-1:0]     rf_rd_data,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic [IDX_WIDTH:0]        error_count,
   output logic                      fail_valid,
   output logic [IDX_WIDTH-1:0]      fail_idx,
   output logic [DATA_WIDTH-1:0]     fail_read
);

   localparam logic [IDX_WIDTH:0] MAX_CNT = (IDX_WIDTH+1)'(NUM_CHECKS);
   localparam logic [1:0]         LAT     = 2'(READ_LATENCY);

   // Mismatch counter increment that sticks at the table depth.
   function automatic logic [IDX_WIDTH:0] sat_inc(input logic [IDX_WIDTH:0] v);
      return (v >= MAX_CNT) ? v : v + 1'b1;
   endfunction

   // Requested entry count limited to the table depth.
   function automatic logic [IDX_WIDTH:0] clamp_num(input logic [IDX_WIDTH:0] n);
      return (n > MAX_CNT) ? MAX_CNT : n;
   endfunction

   state_e                    state_q,      state_d;
   logic [LIMIT_WIDTH-1:0]    wait_cnt_q,   wait_cnt_d;
   logic [LIMIT_WIDTH-1:0]    limit_q,      limit_d;
   logic [IDX_WIDTH:0]        num_q,        num_d;
   logic [IDX_WIDTH:0]        idx_q,        idx_d;
   logic [1:0]                lat_cnt_q,    lat_cnt_d;
   logic                      busy_q,       busy_d;
   logic                      done_q,       done_d;
   logic                      pass_q,       pass_d;
   logic [IDX_WIDTH:0]        err_q,        err_d;
   logic                      fail_valid_q, fail_valid_d;
   logic [IDX_WIDTH-1:0]      fail_idx_q,   fail_idx_d;
   logic [DATA_WIDTH-1:0]     fail_read_q,  fail_read_d;

   logic                      tbl_we;
   logic [REG_ADDR_WIDTH-1:0] tbl_reg;
   logic [DATA_WIDTH-1:0]     tbl_value;
   logic                      idx_done;
   logic                      idx_last;
   logic                      cmp_en;
   logic                      mismatch;
   logic [IDX_WIDTH:0]        err_upd;

   // The table may only be edited while no run is using it.
   assign tbl_we = cfg_we && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   rf_check_table #(
      .DATA_WIDTH     (DATA_WIDTH),
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
      .NUM_CHECKS     (NUM_CHECKS),
      .IDX_WIDTH      (IDX_WIDTH)
   ) u_table (
      .clock    (clock),
      .we       (tbl_we),
      .wr_idx   (cfg_idx),
      .wr_reg   (cfg_reg),
      .wr_value (cfg_value),
      .rd_idx   (idx_q[IDX_WIDTH-1:0]),
      .rd_reg   (tbl_reg),
      .rd_value (tbl_value)
   );

   // Compare point: the ISSUE cycle itself for a zero-latency port, otherwise
   // the last COLLECT cycle; the error count after this cycle's compare.
   always_comb begin
      idx_done = (idx_q >= num_q);
      idx_last = ((idx_q + 1'b1) >= num_q);
      if (READ_LATENCY == 0) begin
         cmp_en = (state_q == ST_ISSUE) && !idx_done;
      end else begin
         cmp_en = (state_q == ST_COLLECT) && (lat_cnt_q == LAT);
      end
      mismatch = cmp_en && (rf_rd_data != tbl_value);
      err_upd  = mismatch ? sat_inc(err_q) : err_q;
   end

   // Next-state, result update and state-decoded read port.
   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      limit_d      = limit_q;
      num_d        = num_q;
      idx_d        = idx_q;
      lat_cnt_d    = lat_cnt_q;
      busy_d       = busy_q;
      done_d       = done_q;
      pass_d       = pass_q;
      err_d        = err_upd;
      fail_valid_d = fail_valid_q;
      fail_idx_d   = fail_idx_q;
      fail_read_d  = fail_read_q;
      rf_rd_en     = 1'b0;
      rf_rd_addr   = '0;

      // First mismatch of a run is captured; later ones only count.
      if (mismatch && !fail_valid_q) begin
         fail_valid_d = 1'b1;
         fail_idx_d   = idx_q[IDX_WIDTH-1:0];
         fail_read_d  = rf_rd_data;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               limit_d      = cycle_limit;
               num_d        = clamp_num(num_checks);
               wait_cnt_d   = '0;
               idx_d        = '0;
               lat_cnt_d    = '0;
               err_d        = '0;
               fail_valid_d = 1'b0;
               fail_idx_d   = '0;
               fail_read_d  = '0;
               done_d       = 1'b0;
               pass_d       = 1'b0;
               busy_d       = 1'b1;
               state_d      = ST_WAIT;
            end
         end
         ST_WAIT: begin
            wait_cnt_d = wait_cnt_q + 1'b1;
            if (wait_cnt_q == limit_q) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (idx_done) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_upd == '0);
            end else begin
               rf_rd_en   = 1'b1;
               rf_rd_addr = tbl_reg;
               if (READ_LATENCY == 0) begin
                  if (idx_last) begin
                     state_d = ST_DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     pass_d  = (err_upd == '0);
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  lat_cnt_d = 2'd1;
                  state_d   = ST_COLLECT;
               end
            end
         end
         ST_COLLECT: begin
            if (lat_cnt_q == LAT) begin
               if (idx_last) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_upd == '0);
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ST_ISSUE;
               end
            end else begin
               lat_cnt_d = lat_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and result registers; reset aborts any run and clears all results.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         wait_cnt_q   <= '0;
         limit_q      <= '0;
         num_q        <= '0;
         idx_q        <= '0;
         lat_cnt_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_q        <= '0;
         fail_valid_q <= 1'b0;
         fail_idx_q   <= '0;
         fail_read_q  <= '0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         limit_q      <= limit_d;
         num_q        <= num_d;
         idx_q        <= idx_d;
         lat_cnt_q    <= lat_cnt_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         err_q        <= err_d;
         fail_valid_q <= fail_valid_d;
         fail_idx_q   <= fail_idx_d;
         fail_read_q  <= fail_read_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign error_count = err_q;
   assign fail_valid  = fail_valid_q;
   assign fail_idx    = fail_idx_q;
   assign fail_read   = fail_read_q;

endmodule

// File: tb/tb_regfile_check_sequencer.sv
// Bench for regfile_check_sequencer: three instances with read latencies 0, 1
// and 3 share one stimulus; each has its own latency-accurate register-file
// read model. Results come from a table-walk reference model.
module tb_regfile_check_sequencer;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NC = 8;
   localparam int IW = 3;
   localparam int LW = 16;
   localparam int NI = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [LW-1:0] cycle_limit;
   logic [IW:0]   num_checks;
   logic          cfg_we;
   logic [IW-1:0] cfg_idx;
   logic [AW-1:0] cfg_reg;
   logic [DW-1:0] cfg_value;

   logic [AW-1:0] rd_addr_w    [NI];
   logic          rd_en_w      [NI];
   logic [DW-1:0] rd_data_w    [NI];
   logic          busy_w       [NI];
   logic          done_w       [NI];
   logic          pass_w       [NI];
   logic [IW:0]   err_w        [NI];
   logic          fail_valid_w [NI];
   logic [IW-1:0] fail_idx_w   [NI];
   logic [DW-1:0] fail_read_w  [NI];

   logic [DW-1:0] regs    [32];
   logic [AW-1:0] tab_reg [NC];
   logic [DW-1:0] tab_val [NC];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   genvar g;
   for (g = 0; g < NI; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 0 : (g == 1) ? 1 : 3;
      logic [DW-1:0] d1, d2, d3;
      always_ff @(posedge clk) begin
         d1 <= regs[rd_addr_w[g]];
         d2 <= d1;
         d3 <= d2;
      end
      assign rd_data_w[g] = (LAT == 0) ? regs[rd_addr_w[g]] : (LAT == 1) ? d1 : d3;

      regfile_check_sequencer #(.READ_LATENCY(LAT)) u_dut (
         .clock       (clk),
         .reset       (rst_n),
         .start       (start),
         .cycle_limit (cycle_limit),
         .num_checks  (num_checks),
         .cfg_we      (cfg_we),
         .cfg_idx     (cfg_idx),
         .cfg_reg     (cfg_reg),
         .cfg_value   (cfg_value),
         .rf_rd_addr  (rd_addr_w[g]),
         .rf_rd_en    (rd_en_w[g]),
         .rf_rd_data  (rd_data_w[g]),
         .busy        (busy_w[g]),
         .done        (done_w[g]),
         .pass        (pass_w[g]),
         .error_count (err_w[g]),
         .fail_valid  (fail_valid_w[g]),
         .fail_idx    (fail_idx_w[g]),
         .fail_read   (fail_read_w[g])
      );
   end

   function automatic int lat_of(input int i);
      return (i == 0) ? 0 : (i == 1) ? 1 : 3;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic write_entry(input int idx, input logic [AW-1:0] r, input logic [DW-1:0] v);
      @(negedge clk);
      cfg_we    = 1'b1;
      cfg_idx   = idx[IW-1:0];
      cfg_reg   = r;
      cfg_value = v;
      @(posedge clk);
      #1 cfg_we = 1'b0;
      tab_reg[idx] = r;
      tab_val[idx] = v;
   endtask

   task automatic check_cleared(input string name);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("%s L%0d busy", name, lat_of(i)), busy_w[i], 0);
         chk($sformatf("%s L%0d done", name, lat_of(i)), done_w[i], 0);
         chk($sformatf("%s L%0d pass", name, lat_of(i)), pass_w[i], 0);
         chk($sformatf("%s L%0d err", name, lat_of(i)), err_w[i], 0);
         chk($sformatf("%s L%0d fail_valid", name, lat_of(i)), fail_valid_w[i], 0);
         chk($sformatf("%s L%0d fail_read", name, lat_of(i)), fail_read_w[i], 0);
         chk($sformatf("%s L%0d rd_en", name, lat_of(i)), rd_en_w[i], 0);
      end
   endtask

   // One complete run checked against the reference model. With disturb set,
   // start and a table write to entry 0 are pulsed during the wait phase.
   task automatic run(input int limit, input int num, input bit disturb, input string name);
      int          n_eff, exp_err, exp_fidx, exp_done, budget;
      bit          exp_fv, all_done;
      logic [DW-1:0] exp_fread;
      int          first_en [NI];
      int          done_at  [NI];
      int          en_cnt   [NI];

      n_eff     = (num > NC) ? NC : num;
      exp_err   = 0;
      exp_fv    = 1'b0;
      exp_fidx  = 0;
      exp_fread = '0;
      for (int k = 0; k < n_eff; k++) begin
         if (regs[tab_reg[k]] != tab_val[k]) begin
            exp_err++;
            if (!exp_fv) begin
               exp_fv    = 1'b1;
               exp_fidx  = k;
               exp_fread = regs[tab_reg[k]];
            end
         end
      end
      for (int i = 0; i < NI; i++) begin
         first_en[i] = -1;
         done_at[i]  = -1;
         en_cnt[i]   = 0;
      end
      budget = limit + 6 + NC * 4;

      @(negedge clk);
      cycle_limit = limit[LW-1:0];
      num_checks  = num[IW:0];
      start       = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;

      for (int cyc = 1; cyc <= budget; cyc++) begin
         @(posedge clk);
         #1;
         all_done = 1'b1;
         for (int i = 0; i < NI; i++) begin
            if (rd_en_w[i]) begin
               if (first_en[i] < 0) first_en[i] = cyc;
               if (en_cnt[i] < NC)
                  chk($sformatf("%s L%0d addr#%0d", name, lat_of(i), en_cnt[i]),
                      rd_addr_w[i], tab_reg[en_cnt[i]]);
               en_cnt[i]++;
            end else begin
               chk($sformatf("%s L%0d idle_addr", name, lat_of(i)), rd_addr_w[i], 0);
            end
            if (done_w[i] && done_at[i] < 0) done_at[i] = cyc;
            if (done_at[i] < 0) all_done = 1'b0;
         end
         if (disturb && cyc == 2) begin
            start     = 1'b1;
            cfg_we    = 1'b1;
            cfg_idx   = '0;
            cfg_reg   = tab_reg[0];
            cfg_value = 32'hFFFF;
         end
         if (disturb && cyc == 3) begin
            start  = 1'b0;
            cfg_we = 1'b0;
         end
         if (all_done) break;
      end

      for (int i = 0; i < NI; i++) begin
         exp_done = (n_eff == 0) ? limit + 2 : limit + 1 + n_eff * (lat_of(i) + 1);
         chk($sformatf("%s L%0d first_en", name, lat_of(i)), first_en[i], (n_eff > 0) ? limit + 1 : -1);
         chk($sformatf("%s L%0d done_at", name, lat_of(i)), done_at[i], exp_done);
         chk($sformatf("%s L%0d en_cnt", name, lat_of(i)), en_cnt[i], n_eff);
         chk($sformatf("%s L%0d busy", name, lat_of(i)), busy_w[i], 0);
         chk($sformatf("%s L%0d done", name, lat_of(i)), done_w[i], 1);
         chk($sformatf("%s L%0d pass", name, lat_of(i)), pass_w[i], (exp_err == 0));
         chk($sformatf("%s L%0d err", name, lat_of(i)), err_w[i], exp_err);
         chk($sformatf("%s L%0d fail_valid", name, lat_of(i)), fail_valid_w[i], exp_fv);
         chk($sformatf("%s L%0d fail_idx", name, lat_of(i)), fail_idx_w[i], exp_fidx);
         chk($sformatf("%s L%0d fail_read", name, lat_of(i)), fail_read_w[i], exp_fread);
      end
   endtask

   task automatic setup_basic(input logic [DW-1:0] r7, input logic [DW-1:0] r11);
      for (int r = 0; r < 32; r++) regs[r] = 32'h5A5A_0000 + r;
      regs[1]  = 32'h0;
      regs[7]  = r7;
      regs[11] = r11;
   endtask

   initial begin
      rst_n       = 1'b1;
      start       = 1'b0;
      cycle_limit = '0;
      num_checks  = '0;
      cfg_we      = 1'b0;
      cfg_idx     = '0;
      cfg_reg     = '0;
      cfg_value   = '0;
      for (int r = 0; r < 32; r++) regs[r] = '0;
      for (int k = 0; k < NC; k++) begin
         tab_reg[k] = '0;
         tab_val[k] = '0;
      end
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_cleared("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Basic table, all matching.
      write_entry(0, 5'd1, 32'h0);
      write_entry(1, 5'd7, 32'hE);
      write_entry(2, 5'd11, 32'hE);
      setup_basic(32'd14, 32'd14);
      run(5, 3, 1'b0, "t1");

      // start and table write during the wait phase are ignored.
      run(5, 3, 1'b1, "t5");

      // Two mismatches; first one at entry 1.
      setup_basic(32'd13, 32'd0);
      run(5, 3, 1'b0, "t2");

      // Empty run.
      run(0, 0, 1'b0, "t3");

      // Every entry mismatches; count reaches the table depth.
      for (int k = 0; k < NC; k++) write_entry(k, AW'(k + 2), regs[k + 2] ^ 32'h1);
      run(3, 8, 1'b0, "t4");
      run(2, 15, 1'b0, "t4clamp");

      // Reset in the middle of a run, then a clean run.
      write_entry(0, 5'd1, 32'h0);
      write_entry(1, 5'd7, 32'hE);
      write_entry(2, 5'd11, 32'hE);
      @(negedge clk);
      cycle_limit = 16'd5;
      num_checks  = 4'd3;
      start       = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_cleared("t6rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_cleared("t6after");
      setup_basic(32'd14, 32'd14);
      run(5, 3, 1'b0, "t6run");

      // Randomized tables, register contents, limits and entry counts.
      for (int it = 0; it < 12; it++) begin
         for (int r = 0; r < 32; r++) regs[r] = $urandom;
         for (int k = 0; k < NC; k++) begin
            logic [AW-1:0] rr;
            rr = AW'($urandom_range(0, 31));
            write_entry(k, rr, ($urandom_range(0, 1) == 1) ? regs[rr] : $urandom);
         end
         run($urandom_range(0, 9), $urandom_range(0, 15), 1'b0, $sformatf("rnd%0d", it));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
